mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning idle-handshake cycles before a forced release (range 1..255).
REQ-002 SHALL have one clock and an asynchronous, active-high reset, listed first:
- clk  in  1  clock
- rst  in  1  reset
REQ-003 SHALL have the following per-port signals, indexed [1:0] (port 0 = I-cache controller, port 1 = D-cache controller):
- req_rd  in  2  read_en_mem from each cache controller
- req_wr  in  2  write_en_mem from each cache controller
- req_valid_cache  in  2  valid_cache from each cache controller
- req_ready_cache  in  2  ready_cache from each cache controller
- req_addr  in  2xADDR_W  block address per port
- req_wdata  in  2xBLOCK_W  write-back block per port
- port_ready_mem  out  2  ready_mem returned to each port
- port_valid_mem  out  2  valid_mem returned to each port
- port_rdata  out  BLOCK_W  refill block, broadcast to both ports
REQ-004 SHALL have the following memory-side signals:
- mem_read_en  out  1
- mem_write_en  out  1
- mem_addr  out  ADDR_W
- mem_wdata  out  BLOCK_W
- mem_valid_cache  out  1
- mem_ready_cache  out  1
- mem_ready_mem  in  1
- mem_valid_mem  in  1
- mem_rdata  in  BLOCK_W
REQ-005 SHALL have the following status outputs:
- grant  out  2  one-hot owner, 0 when idle
- busy  out  1  high in BUSY
- timeout  out  1  one-cycle pulse on forced release

Function
REQ-006 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-007 In IDLE, any request (req_rd|req_wr) on a port SHALL register a grant; the FSM enters BUSY next cycle, giving one cycle of arbitration latency.
REQ-008 A single requester SHALL be granted that port; simultaneous requesters SHALL be granted the port != last_grant (round-robin); last_grant updates on every grant.
REQ-009 In BUSY, the owner g SHALL be routed combinationally as follows:
- mem_read_en=req_rd[g], mem_write_en=req_wr[g], mem_addr=req_addr[g], mem_wdata=req_wdata[g], mem_valid_cache=req_valid_cache[g], mem_ready_cache=req_ready_cache[g]
- port_ready_mem[g]=mem_ready_mem, port_valid_mem[g]=mem_valid_mem
REQ-010 The non-owner's port_ready_mem/port_valid_mem SHALL be 0; its requests SHALL be held pending without loss, with no queue beyond the level request.
REQ-011 The grant SHALL stay locked across write-back followed by allocate; BUSY→IDLE only in a cycle where req_rd[g]=0 and req_wr[g]=0.
REQ-012 In IDLE, all mem_* outputs and port_* handshake outputs SHALL be 0; port_rdata=mem_rdata at all times.
REQ-013 Back-to-back transactions SHALL have at least one IDLE cycle between grants.

Reset
REQ-014 On rst: state=IDLE, last_grant=1 (port 0 wins first tie), grant=0, busy=0, timeout=0, timeout counter=0; takes effect immediately, including mid-transfer, with all mem_* outputs 0.

Configuration
REQ-015 With MEM_ARB_TIMEOUT_EN defined, the watchdog SHALL behave as follows:
- an 8-bit counter clears on BUSY entry or on any memory handshake (mem_valid_cache&mem_ready_mem or mem_valid_mem&mem_ready_cache), and increments otherwise in BUSY
- on reaching TIMEOUT_CYCLES, timeout pulses for 1 cycle and the FSM forces IDLE
REQ-016 Without MEM_ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied 0, and BUSY SHALL exit only per REQ-011.

Structure
REQ-017 Package mem_arb_pkg SHALL hold ADDR_W=32, BLOCK_W=128, the arb_state_t enum (IDLE, BUSY) and the port index constants.
REQ-018 One sub-module, rr_arbiter2 (2-port round-robin pick from request vector and last_grant), SHALL implement the arbitration.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Only port1 reads, memory returns data 0xA5.. after 3 cycles -> grant=2'b10 one cycle later; port_valid_mem[1]=1; port_valid_mem[0]=0 throughout.
- Both ports request in the same cycle after reset -> port0 granted; after release, port1 granted after exactly one IDLE cycle.
- Port1 does write-back (mem_ready_mem delayed 2 cycles) then refill while port0 requests -> grant stays 2'b10 through both phases; port0 is granted only after port1 drops.
- rst asserted mid-refill -> same-cycle mem_read_en=0, grant=0, busy=0; after release, a tie grants port0.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and memory never responding -> timeout pulses 4 cycles after BUSY entry, then IDLE; without the macro, busy stays 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-to-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned PORT_ICACHE = 0;
  localparam int unsigned PORT_DCACHE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o,
  output logic       any_o
);

  // Select the winning port index from the request vector.
  always_comb begin
    gnt_idx_o = 1'b0;
    case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

  assign any_o = |req_i;
  assign gnt_o = any_o ? port_onehot(gnt_idx_o) : 2'b00;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory channel between the I-cache (port 0) and the
// D-cache (port 1) controllers. The grant is held for as long as the owner
// keeps a read or write request up, so write-back followed by allocate stays
// on one port. Build option MEM_ARB_TIMEOUT_EN adds a watchdog that forces
// a release after TIMEOUT_CYCLES cycles without a memory handshake.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_rd,
  input  logic [1:0]           req_wr,
  input  logic [1:0]           req_valid_cache,
  input  logic [1:0]           req_ready_cache,
  input  logic [2*ADDR_W-1:0]  req_addr,
  input  logic [2*BLOCK_W-1:0] req_wdata,
  output logic [1:0]           port_ready_mem,
  output logic [1:0]           port_valid_mem,
  output logic [BLOCK_W-1:0]   port_rdata,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [BLOCK_W-1:0]   mem_wdata,
  output logic                 mem_valid_cache,
  output logic                 mem_ready_cache,
  input  logic                 mem_ready_mem,
  input  logic                 mem_valid_mem,
  input  logic [BLOCK_W-1:0]   mem_rdata,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 timeout
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;

  logic [1:0] req_any;
  logic [1:0] arb_gnt;
  logic       arb_idx;
  logic       arb_any;
  logic       owner;
  logic       own_req;
  logic       wd_expire;

  assign req_any = req_rd | req_wr;
  assign owner   = grant_q[PORT_DCACHE];
  assign own_req = req_any[owner];

  rr_arbiter2 u_rr (
    .req_i     (req_any),
    .last_i    (last_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // State, grant and round-robin history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state: grant from IDLE, release when the owner drops or the watchdog fires.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = BUSY;
          grant_d = arb_gnt;
          last_d  = arb_idx;
        end
      end
      BUSY: begin
        if (!own_req || wd_expire) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Route the owner's request to memory and memory's handshake back to the owner only.
  always_comb begin
    mem_read_en     = 1'b0;
    mem_write_en    = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_valid_cache = 1'b0;
    mem_ready_cache = 1'b0;
    port_ready_mem  = '0;
    port_valid_mem  = '0;
    if (state_q == BUSY) begin
      mem_read_en     = req_rd[owner];
      mem_write_en    = req_wr[owner];
      mem_addr        = owner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      mem_wdata       = owner ? req_wdata[2*BLOCK_W-1:BLOCK_W] : req_wdata[BLOCK_W-1:0];
      mem_valid_cache = req_valid_cache[owner];
      mem_ready_cache = req_ready_cache[owner];
      port_ready_mem[owner] = mem_ready_mem;
      port_valid_mem[owner] = mem_valid_mem;
    end
  end

  assign port_rdata = mem_rdata;
  assign grant      = grant_q;
  assign busy       = (state_q == BUSY);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q;
  logic       mem_hs;

  assign mem_hs = (mem_valid_cache & mem_ready_mem) | (mem_valid_mem & mem_ready_cache);
  // Fires on the cycle the count would reach TIMEOUT_CYCLES; a normal release wins.
  assign wd_expire = (state_q == BUSY) && own_req && !mem_hs && (cnt_q == TMO_LAST);

  // Idle-handshake counter: runs only while BUSY and no handshake is seen.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if ((state_q != BUSY) || !own_req || mem_hs || wd_expire) begin
      cnt_d = '0;
    end
  end

  // Watchdog count and one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= wd_expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
